// File: rtl/qspi_pkg.sv
// qspi_pkg: lane-mode encodings, transceiver states and per-mode geometry helpers
// shared by the QSPI slave transceiver.
package qspi_pkg;
   typedef enum logic [1:0] {
      MODE_SINGLE = 2'b00,
      MODE_DUAL   = 2'b01,
      MODE_QUAD   = 2'b10,
      MODE_RSVD   = 2'b11
   } qspi_mode_e;
   typedef enum logic [1:0] {
      ST_DISARMED = 2'b00,
      ST_IDLE     = 2'b01,
      ST_FRAME    = 2'b10
   } qspi_state_e;
   localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hFF;
   // A quad request on a two-lane build falls back to dual; reserved behaves as single.
   function automatic logic [2:0] lanes_per_mode(input qspi_mode_e m, input int unsigned lanes);
      return m == MODE_QUAD ? (lanes >= 4 ? 3'd4 : 3'd2) : m == MODE_DUAL ? 3'd2 : 3'd1;
   endfunction
   function automatic logic [3:0] edges_per_byte(input logic [2:0] l);
      return l == 3'd4 ? 4'd2 : l == 3'd2 ? 4'd4 : 4'd8;
   endfunction
endpackage

// File: rtl/qspi_sync.sv
// qspi_sync: multi-flop synchroniser for a W-bit bus with registered rise/fall strobes
// that line up with the registered level output.
module qspi_sync #(
   parameter int unsigned W      = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o,
   output logic [W-1:0] rise_o,
   output logic [W-1:0] fall_o
);
   logic [W-1:0] sync_q [STAGES];
   logic [W-1:0] lvl_q;
   logic [W-1:0] rise_q;
   logic [W-1:0] fall_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(STAGES); i++) sync_q[i] <= '0;
         lvl_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < int'(STAGES); i++) sync_q[i] <= sync_q[i-1];
         lvl_q  <= sync_q[STAGES-1];
         rise_q <= sync_q[STAGES-1] & ~lvl_q;
         fall_q <= ~sync_q[STAGES-1] & lvl_q;
      end
   end
   assign q_o    = lvl_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;
endmodule

// File: rtl/qspi_slave_xcvr.sv
// qspi_slave_xcvr: oversampled single/dual/quad QSPI slave (SPI mode 0) with an rx byte
// strobe, a one-deep tx holding register and pad output/enable drive for tristate cells.
module qspi_slave_xcvr
   import qspi_pkg::*;
#(
   parameter int unsigned LANES       = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic             dir,
   input  logic             io_ss,
   input  logic             io_sclk,
   input  logic [LANES-1:0] io_qd_read,
   output logic [LANES-1:0] io_qd_write,
   output logic [LANES-1:0] io_qd_writeEnable,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             tx_underrun,
   output logic             busy
);
   logic ss_lvl, ss_rise, ss_fall, sclk_lvl, sclk_rise, sclk_fall;
   logic [LANES-1:0] qd_s, qd_rise_unused, qd_fall_unused;
   logic sync_unused;
   qspi_sync #(.W(1), .STAGES(SYNC_STAGES)) u_ss (
      .clk(clk), .reset(reset), .d_i(io_ss), .q_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
   );
   qspi_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sclk (
      .clk(clk), .reset(reset), .d_i(io_sclk), .q_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );
   qspi_sync #(.W(LANES), .STAGES(SYNC_STAGES)) u_qd (
      .clk(clk), .reset(reset), .d_i(io_qd_read), .q_o(qd_s), .rise_o(qd_rise_unused), .fall_o(qd_fall_unused)
   );
   assign sync_unused = ^{sclk_lvl, qd_rise_unused, qd_fall_unused};
   qspi_state_e state_q, state_d;
   logic [2:0] lanes_q, lanes_d, cnt_q, cnt_d;
   logic dir_q, dir_d, rx_valid_q, rx_valid_d, hold_full_q, hold_full_d;
   logic underrun_q, underrun_d, load_pend_q, load_pend_d;
   logic [7:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d, tx_sh_q, tx_sh_d, hold_q, hold_d;
   logic active, start, load, last_edge, rx_en;
   logic [3:0] qd4, wr4, en4;
   logic [7:0] rx_next, next_byte;
   // A synchronised ss rise outranks any sclk edge seen in the same cycle.
   assign active    = state_q == ST_FRAME && !ss_rise;
   assign start     = state_q == ST_IDLE && ss_fall;
   assign load      = start || (active && sclk_fall && load_pend_q);
   assign last_edge = cnt_q == 3'(edges_per_byte(lanes_q) - 4'd1);
   assign rx_en     = lanes_q == 3'd1 || !dir_q;
   assign qd4       = 4'(qd_s);
   assign rx_next   = lanes_q == 3'd4 ? {rx_sh_q[3:0], qd4} :
                      lanes_q == 3'd2 ? {rx_sh_q[5:0], qd4[1:0]} : {rx_sh_q[6:0], qd4[0]};
   assign next_byte = hold_full_q ? hold_q : tx_valid ? tx_data : IDLE_BYTE;
   assign wr4       = lanes_q == 3'd4 ? tx_sh_q[7:4] :
                      lanes_q == 3'd2 ? {2'b00, tx_sh_q[7:6]} : {2'b00, tx_sh_q[7], 1'b0};
   assign en4       = lanes_q == 3'd1 ? 4'b0010 : !dir_q ? 4'b0000 :
                      lanes_q == 3'd2 ? 4'b0011 : 4'b1111;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_DISARMED;
         lanes_q     <= 3'd1;
         dir_q       <= 1'b0;
         cnt_q       <= '0;
         rx_sh_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         tx_sh_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         underrun_q  <= 1'b0;
         load_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lanes_q     <= lanes_d;
         dir_q       <= dir_d;
         cnt_q       <= cnt_d;
         rx_sh_q     <= rx_sh_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         tx_sh_q     <= tx_sh_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         underrun_q  <= underrun_d;
         load_pend_q <= load_pend_d;
      end
   end
   always_comb begin
      state_d     = state_q;
      lanes_d     = lanes_q;
      dir_d       = dir_q;
      cnt_d       = cnt_q;
      rx_sh_d     = rx_sh_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      tx_sh_d     = tx_sh_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      underrun_d  = 1'b0;
      load_pend_d = load_pend_q;
      case (state_q)
         ST_DISARMED: state_d = ss_lvl ? ST_IDLE : ST_DISARMED;
         ST_IDLE: if (ss_fall) begin
            state_d = ST_FRAME;
            lanes_d = lanes_per_mode(qspi_mode_e'(mode), LANES);
            dir_d   = dir;
            cnt_d   = '0;
            rx_sh_d = '0;
         end
         ST_FRAME: if (ss_rise) begin
            state_d     = ST_IDLE;
            load_pend_d = 1'b0;
         end else if (sclk_rise) begin
            rx_sh_d     = rx_next;
            cnt_d       = last_edge ? 3'd0 : cnt_q + 3'd1;
            load_pend_d = load_pend_q | last_edge;
            rx_valid_d  = last_edge & rx_en;
            rx_data_d   = last_edge && rx_en ? rx_next : rx_data_q;
         end else if (sclk_fall && !load_pend_q) begin
            tx_sh_d = tx_sh_q << lanes_q;
         end
         default: state_d = ST_DISARMED;
      endcase
      // An empty holding register lets a same-cycle offer go straight into the shifter.
      if (load) begin
         tx_sh_d     = next_byte;
         load_pend_d = 1'b0;
         hold_full_d = 1'b0;
         underrun_d  = !hold_full_q && !tx_valid;
      end else if (tx_valid && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
   end
   assign io_qd_write       = active ? wr4[LANES-1:0] : '0;
   assign io_qd_writeEnable = active ? en4[LANES-1:0] : '0;
   assign rx_data           = rx_data_q;
   assign rx_valid          = rx_valid_q;
   assign tx_ready          = !hold_full_q;
   assign tx_underrun       = underrun_q;
   assign busy              = active;
endmodule

// File: tb/tb_qspi_slave_xcvr.sv
// tb_qspi_slave_xcvr: drives SPI-mode-0 master frames and compares received bytes, lane
// traffic, enables and underruns with a queue-level model of the slave.
module tb_qspi_slave_xcvr;
   logic clk = 1'b0, reset = 1'b1;
   logic [1:0] mode = 2'b00;
   logic dir = 1'b0, io_ss = 1'b1, io_sclk = 1'b0;
   logic [3:0] io_qd_read = 4'h0;
   logic [3:0] io_qd_write, io_qd_writeEnable;
   logic [7:0] rx_data, tx_data = 8'h00;
   logic rx_valid, tx_valid = 1'b0, tx_ready, tx_underrun, busy;
   int checks = 0, errors = 0, und = 0, exp_und = 0;
   logic acc_ok = 1'b0, en_bad = 1'b0;
   logic [7:0] txq[$], txm[$], rxq[$], exp_tx[$];
   logic [7:0] m_out [4];
   logic [7:0] m_in [4];
   always #5 clk = ~clk;
   qspi_slave_xcvr #(.LANES(4), .SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
      .clk(clk), .reset(reset), .mode(mode), .dir(dir), .io_ss(io_ss), .io_sclk(io_sclk),
      .io_qd_read(io_qd_read), .io_qd_write(io_qd_write), .io_qd_writeEnable(io_qd_writeEnable),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_underrun(tx_underrun), .busy(busy)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Every wait goes through here: feeds the tx handshake and records rx/underrun strobes.
   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         if (tx_valid && acc_ok) void'(txq.pop_front());
         tx_valid = txq.size() != 0;
         tx_data = tx_valid ? txq[0] : 8'h00;
         acc_ok = tx_ready && !reset;
         if (rx_valid) rxq.push_back(rx_data);
         if (tx_underrun) und++;
      end
   endtask
   task automatic push(input logic [7:0] b);
      txq.push_back(b);
      txm.push_back(b);
   endtask
   task automatic model_load();
      if (txm.size() != 0) exp_tx.push_back(txm.pop_front());
      else begin
         exp_tx.push_back(8'hFF);
         exp_und++;
      end
   endtask
   task automatic edges(input int l, input int n, input int late_at, input logic [7:0] late_b,
                        input logic [3:0] exp_en, input logic exp_busy);
      int epb, b, k, bits;
      epb = 8 / l;
      for (int e = 0; e < n; e++) begin
         b = e / epb;
         k = e % epb;
         if (e == late_at) push(late_b);
         io_qd_read = 4'((int'(m_out[b]) >> (8 - l * (k + 1))) & ((1 << l) - 1));
         cyc(6);
         bits = l == 1 ? int'(io_qd_write[1]) : int'(io_qd_write) & ((1 << l) - 1);
         m_in[b] = 8'((int'(m_in[b]) << l) | bits);
         if (io_qd_writeEnable !== exp_en || busy !== exp_busy) en_bad = 1'b1;
         io_sclk = 1'b1;
         cyc(6);
         io_sclk = 1'b0;
         if ((e + 1) % epb == 0) model_load();
      end
   endtask
   task automatic frame(input logic [1:0] md, input logic dr, input int nb, input int cut,
                        input int late_at, input logic [7:0] late_b);
      int l, n, nc, nrx;
      logic [3:0] ee;
      l = md == 2'b10 ? 4 : md == 2'b01 ? 2 : 1;
      ee = l == 1 ? 4'b0010 : !dr ? 4'b0000 : l == 2 ? 4'b0011 : 4'b1111;
      n = cut > 0 ? cut : nb * (8 / l);
      nc = n / (8 / l);
      nrx = (l == 1 || !dr) ? nc : 0;
      mode = md;
      dir = dr;
      rxq.delete();
      exp_tx.delete();
      und = 0;
      exp_und = 0;
      en_bad = 1'b0;
      for (int i = 0; i < 4; i++) m_in[i] = 8'h00;
      cyc(4);
      io_ss = 1'b0;
      model_load();
      cyc(10);
      mode = 2'($urandom);
      dir = 1'($urandom);
      edges(l, n, late_at, late_b, ee, 1'b1);
      cyc(6);
      io_ss = 1'b1;
      cyc(12);
      chk($sformatf("en_busy_in_frame m%0d d%0d", md, dr), 32'(en_bad), 0);
      chk("en_after_ss_rise", 32'(io_qd_writeEnable), 0);
      chk("busy_after_ss_rise", 32'(busy), 0);
      chk("rx_count", rxq.size(), nrx);
      for (int i = 0; i < nrx && i < rxq.size(); i++) chk($sformatf("rx_byte%0d", i), 32'(rxq[i]), 32'(m_out[i]));
      if (l == 1 || dr) for (int i = 0; i < nc; i++) chk($sformatf("tx_byte%0d", i), 32'(m_in[i]), 32'(exp_tx[i]));
      chk("underruns", und, exp_und);
   endtask
   initial begin
      cyc(3);
      reset = 1'b0;
      cyc(2);
      chk("rst_rx_data", 32'(rx_data), 0);
      chk("rst_rx_valid", 32'(rx_valid), 0);
      chk("rst_tx_ready", 32'(tx_ready), 1);
      chk("rst_tx_underrun", 32'(tx_underrun), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_write", 32'(io_qd_write), 0);
      chk("rst_enable", 32'(io_qd_writeEnable), 0);
      m_out[0] = 8'hA5;
      push(8'h3C);
      frame(2'b00, 1'b0, 1, 0, -1, 8'h00);
      m_out[0] = 8'h12;
      m_out[1] = 8'h34;
      frame(2'b01, 1'b0, 2, 0, -1, 8'h00);
      push(8'hDE);
      push(8'hAD);
      frame(2'b10, 1'b1, 2, 0, -1, 8'h00);
      push(8'hDE);
      frame(2'b10, 1'b1, 2, 0, 3, 8'h5A);
      m_out[0] = 8'(($urandom));
      frame(2'b00, 1'b0, 1, 5, -1, 8'h00);
      m_out[0] = 8'(($urandom));
      frame(2'b00, 1'b0, 1, 0, -1, 8'h00);
      mode = 2'b00;
      dir = 1'b0;
      m_out[0] = 8'h96;
      io_ss = 1'b0;
      cyc(10);
      edges(1, 3, -1, 8'h00, 4'b0010, 1'b1);
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      rxq.delete();
      cyc(1);
      chk("midrst_rx_data", 32'(rx_data), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_enable", 32'(io_qd_writeEnable), 0);
      chk("midrst_write", 32'(io_qd_write), 0);
      chk("midrst_tx_ready", 32'(tx_ready), 1);
      en_bad = 1'b0;
      edges(1, 8, -1, 8'h00, 4'b0000, 1'b0);
      chk("no_rx_while_disarmed", rxq.size(), 0);
      chk("disarmed_en_busy", 32'(en_bad), 0);
      io_ss = 1'b1;
      cyc(10);
      m_out[0] = 8'(($urandom));
      frame(2'b00, 1'b0, 1, 0, -1, 8'h00);
      repeat (5) begin
         logic [1:0] md;
         logic dr;
         int nb, nq;
         md = 2'($urandom_range(0, 3));
         dr = 1'($urandom_range(0, 1));
         nb = $urandom_range(1, 3);
         nq = $urandom_range(0, 2);
         for (int i = 0; i < 4; i++) m_out[i] = 8'($urandom);
         for (int i = 0; i < nq; i++) push(8'($urandom));
         frame(md, dr, nb, 0, -1, 8'h00);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/qspi_slave_xcvr.md
Name: qspi_slave_xcvr

Overview:
Parametrised QSPI slave transceiver that replaces the fixed dual-lane slave sitting behind the SB_IO pad cells. It oversamples sclk, ss and up to 4 data lanes on the system clock, and supports single, dual and quad modes. It delivers received bytes and accepts transmit bytes over valid/ready handshakes. It drives the pad output/output-enable vectors that feed the tristate SB_IO instances.

Parameters:
LANES, 4, number of physical data lanes (2 or 4); with 2, a quad request is treated as dual
SYNC_STAGES, 2, flip-flop depth of the input synchronisers (>=2)
IDLE_BYTE, 8'hFF, byte shifted out on transmit underrun

Ports:
clk  in  1  system clock; must be >= 6x sclk frequency
reset  in  1  synchronous reset, active-high
mode  in  2  lane mode: 00 single, 01 dual, 10 quad, 11 reserved (treated as single)
dir  in  1  dual/quad only: 0 = master writes, 1 = slave drives
io_ss  in  1  chip select, active-low, asynchronous to clk
io_sclk  in  1  serial clock, SPI mode 0, asynchronous to clk
io_qd_read  in  LANES  pad input values
io_qd_write  out  LANES  pad output values
io_qd_writeEnable  out  LANES  per-lane output enable
rx_data  out  8  received byte
rx_valid  out  1  one-cycle strobe; rx_data is valid while it is high
tx_data  in  8  byte to transmit
tx_valid  in  1  tx_data offered
tx_ready  out  1  holding register empty
tx_underrun  out  1  one-cycle pulse when IDLE_BYTE is substituted
busy  out  1  frame active (synchronised ss low)

Behaviour:
- Reset values: rx_data=0, rx_valid=0, tx_ready=1, tx_underrun=0, busy=0, io_qd_write=0, io_qd_writeEnable=0. Holding register empty, counters cleared, frame disarmed.
- Arming: after reset, a frame may start only after synchronised ss has been seen high. Reset mid-frame therefore ignores the rest of that frame.
- Synchronisation: io_ss, io_sclk and io_qd_read each pass through SYNC_STAGES flops. Rise and fall edges of sclk come from the last two stages.
- Frame start (ss falls): latch mode and dir for the whole frame; a mode change mid-frame is ignored. Set busy=1 and clear the bit counter. Load the tx shifter from holding (or IDLE_BYTE, pulsing tx_underrun) and drive its top lanes immediately.
- Lanes per edge: L = 1/2/4 for single/dual/quad. Edges per byte = 8/L, so the counter wraps at 7, 3 or 1.
- Bit order: MSB first. Within an edge the highest-numbered lane carries the most significant bit.
- Single mode: full duplex. Receive on lane 0, transmit on lane 1. writeEnable = 4'b0010 (masked to LANES) while busy.
- Dual/quad mode: half duplex per dir. dir=0: all enables 0, receive on lanes [L-1:0]. dir=1: enables set on lanes [L-1:0] only, no receive strobes.
- Receive: shift on each sclk rise. On the rise that completes a byte, rx_data updates and rx_valid pulses for exactly 1 cycle. rx_valid is high SYNC_STAGES+2 clk edges after the raw sclk rise. There is no backpressure; the consumer must take the byte that cycle.
- Transmit: shift out on each sclk fall. On the first fall after a byte-completing rise, load the next byte from holding. If holding is empty, load IDLE_BYTE and pulse tx_underrun.
- Holding handshake: tx_ready = holding empty; a byte is accepted on tx_valid & tx_ready. If a load occurs in the same cycle as acceptance while holding is empty, the byte bypasses holding into the shifter and tx_ready stays 1.
- Frame end (ss rises, any bit position): the partial rx byte is discarded with no rx_valid. Enables drop to 0 on the same cycle the synchronised ss rise is seen, and busy goes to 0. The holding register keeps its contents.
- Simultaneous ss rise and sclk edge in the same cycle: ss wins and the edge is ignored.

Decomposition:
- Package qspi_pkg: mode encodings (MODE_SINGLE/DUAL/QUAD), a lanes_per_mode() function, an edges_per_byte() function, and the IDLE_BYTE default.
- Sub-module qspi_sync: SYNC_STAGES synchroniser plus rise/fall edge detect, instantiated for sclk/ss, with a vector variant for qd.

Test Plan:
- Single mode: master sends 0xA5 on lane 0 with tx holding 0x3C preloaded. Expect rx_valid once with rx_data=0xA5, and lane 1 carrying 0x3C MSB first.
- Dual mode, dir=0: bytes 0x12, 0x34 over 8 sclk cycles. Expect two rx_valid pulses with 0x12 then 0x34, writeEnable=0 throughout.
- Quad mode, dir=1, LANES=4: tx bytes 0xDE, 0xAD queued. Expect nibbles D,E,A,D on lanes [3:0], writeEnable=4'hF during the frame and 0 after ss rises.
- Underrun: quad mode, dir=1, holding empty at the second byte boundary. Expect IDLE_BYTE 0xFF on the wire and one tx_underrun pulse.
- Abort: ss rises after 5 single-mode bits. Expect no rx_valid, busy=0; the next frame's first byte is received correctly.
- Reset asserted mid-frame while ss is held low. Expect all outputs at reset values and no rx_valid until ss has gone high and then low again.
